// File: rtl/bsg_manycore_bank_arb_pkg.sv
// Shared constants and width helpers for the local-memory bank arbiter.
package bsg_manycore_bank_arb_pkg;

  localparam int unsigned port_inst_lp   = 0;
  localparam int unsigned port_remote_lp = 1;
  localparam int unsigned port_dmem_lp   = 2;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int bank_sel_width(input int num_banks);
    return id_width(num_banks);
  endfunction

  function automatic int port_id_width(input int num_ports);
    return id_width(num_ports);
  endfunction

  function automatic int cnt_width(input int limit);
    return id_width(limit + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_bank_arb_starve_ctr.sv
// Per-port saturating stall counter; flags a port that has waited too long.
module bsg_manycore_bank_arb_starve_ctr
  import bsg_manycore_bank_arb_pkg::*;
#(
  parameter int starve_limit_p = 7,
  parameter int cnt_width_lp   = cnt_width(starve_limit_p)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  logic yumi_i,
  output logic urgent_o
);

  localparam logic [cnt_width_lp-1:0] lim_lp =
    cnt_width_lp'(starve_limit_p);

  logic [cnt_width_lp-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= '0;
    end else if ((starve_limit_p == 0) || yumi_i || !v_i) begin
      r_cnt <= '0;
    end else if (r_cnt != lim_lp) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign urgent_o = (starve_limit_p != 0) && (r_cnt == lim_lp);

endmodule

// File: rtl/bsg_manycore_bank_arb.sv
// Per-bank arbiter: fixed priority (highest index) with starvation aging.
module bsg_manycore_bank_arb
  import bsg_manycore_bank_arb_pkg::*;
#(
  parameter int num_ports_p       = 3,
  parameter int num_banks_p       = 4,
  parameter int starve_limit_p    = 7,
  parameter int bank_sel_width_lp = bank_sel_width(num_banks_p),
  parameter int port_id_width_lp  = port_id_width(num_ports_p),
  parameter int cnt_width_lp      = cnt_width(starve_limit_p)
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic [num_ports_p-1:0]                         v_i,
  input  logic [num_ports_p-1:0][bank_sel_width_lp-1:0]  bank_i,
  input  logic [num_ports_p-1:0]                         w_i,
  output logic [num_ports_p-1:0]                         yumi_o,
  output logic [num_banks_p-1:0]                         bank_v_o,
  output logic [num_banks_p-1:0]                         bank_w_o,
  output logic [num_banks_p-1:0][port_id_width_lp-1:0]   bank_port_o,
  output logic [num_ports_p-1:0]                         rv_o,
  output logic [num_ports_p-1:0]                         urgent_o
);

  logic [num_ports_p-1:0]                   w_urgent;
  logic [num_banks_p-1:0][num_ports_p-1:0]  w_gnt_all;
  logic [num_ports_p-1:0]                   w_yumi;
  logic [num_ports_p-1:0]                   r_rv;

  for (genvar p = 0; p < num_ports_p; p++) begin : g_port
    bsg_manycore_bank_arb_starve_ctr #(
      .starve_limit_p (starve_limit_p),
      .cnt_width_lp   (cnt_width_lp)
    ) u_ctr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .v_i      (v_i[p]),
      .yumi_i   (w_yumi[p]),
      .urgent_o (w_urgent[p])
    );
  end

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    logic [num_ports_p-1:0]      w_cand;
    logic [num_ports_p-1:0]      w_gnt;
    logic [port_id_width_lp-1:0] w_win;

    // Later assignments override: urgent scan runs last, lowest index wins.
    always_comb begin
      w_cand = '0;
      w_win  = '0;
      for (int p = 0; p < num_ports_p; p++) begin
        w_cand[p] = v_i[p] && (bank_i[p] == bank_sel_width_lp'(b));
      end
      for (int p = 0; p < num_ports_p; p++) begin
        if (w_cand[p]) w_win = port_id_width_lp'(p);
      end
      for (int p = num_ports_p - 1; p >= 0; p--) begin
        if (w_cand[p] && w_urgent[p]) w_win = port_id_width_lp'(p);
      end
    end

    always_comb begin
      w_gnt = '0;
      for (int p = 0; p < num_ports_p; p++) begin
        w_gnt[p] = reset_i && w_cand[p] &&
                   (w_win == port_id_width_lp'(p));
      end
    end

    assign w_gnt_all[b]   = w_gnt;
    assign bank_v_o[b]    = reset_i && (|w_cand);
    assign bank_w_o[b]    = |(w_gnt & w_i);
    assign bank_port_o[b] = reset_i ? w_win : '0;
  end

  always_comb begin
    w_yumi = '0;
    for (int b = 0; b < num_banks_p; b++) begin
      w_yumi = w_yumi | w_gnt_all[b];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rv <= '0;
    end else begin
      r_rv <= w_yumi & ~w_i;
    end
  end

  assign yumi_o   = w_yumi;
  assign rv_o     = r_rv;
  assign urgent_o = w_urgent;

endmodule

// File: tb/tb_bsg_manycore_bank_arb.sv
// Directed bench for the bank arbiter at starve limits 3, 7 and 0.
module tb_bsg_manycore_bank_arb;

  logic            clk;
  logic            reset_i;
  logic [2:0]      v_i;
  logic [2:0][1:0] bank_i;
  logic [2:0]      w_i;

  logic [2:0]      yumi3, rv3, urg3;
  logic [3:0]      bv3, bw3;
  logic [3:0][1:0] bp3;
  logic [2:0]      yumi7, rv7, urg7;
  logic [3:0]      bv7, bw7;
  logic [3:0][1:0] bp7;
  logic [2:0]      yumi0, rv0, urg0;
  logic [3:0]      bv0, bw0;
  logic [3:0][1:0] bp0;

  int checks;
  int failures;

  bsg_manycore_bank_arb #(.starve_limit_p(3)) u3 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .bank_i(bank_i),
    .w_i(w_i), .yumi_o(yumi3), .bank_v_o(bv3), .bank_w_o(bw3),
    .bank_port_o(bp3), .rv_o(rv3), .urgent_o(urg3)
  );

  bsg_manycore_bank_arb #(.starve_limit_p(7)) u7 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .bank_i(bank_i),
    .w_i(w_i), .yumi_o(yumi7), .bank_v_o(bv7), .bank_w_o(bw7),
    .bank_port_o(bp7), .rv_o(rv7), .urgent_o(urg7)
  );

  bsg_manycore_bank_arb #(.starve_limit_p(0)) u0 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .bank_i(bank_i),
    .w_i(w_i), .yumi_o(yumi0), .bank_v_o(bv0), .bank_w_o(bw0),
    .bank_port_o(bp0), .rv_o(rv0), .urgent_o(urg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [5:0] bank;
    logic [2:0] w;
    logic [2:0] yumi;
    logic [3:0] bv;
    logic [3:0] bw;
    logic [7:0] bp;
    logic [2:0] urg;
    logic [2:0] rv;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] v, input logic [5:0] b,
                      input logic [2:0] w);
    @(negedge clk);
    v_i    = v;
    bank_i = b;
    w_i    = w;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b0;
    v_i     = '0;
    bank_i  = '0;
    w_i     = '0;
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // all three on bank1 (limit 3), then distinct banks, then idle
    tbl[0] = '{3'b111, 6'b010101, 3'b000, 3'b100, 4'b0010, 4'b0000, 8'h08, 3'b000, 3'b000};
    tbl[1] = '{3'b111, 6'b010101, 3'b000, 3'b100, 4'b0010, 4'b0000, 8'h08, 3'b000, 3'b100};
    tbl[2] = '{3'b111, 6'b010101, 3'b000, 3'b100, 4'b0010, 4'b0000, 8'h08, 3'b000, 3'b100};
    tbl[3] = '{3'b111, 6'b010101, 3'b000, 3'b001, 4'b0010, 4'b0000, 8'h00, 3'b011, 3'b100};
    tbl[4] = '{3'b111, 6'b010101, 3'b000, 3'b010, 4'b0010, 4'b0000, 8'h04, 3'b010, 3'b001};
    tbl[5] = '{3'b111, 6'b010101, 3'b000, 3'b100, 4'b0010, 4'b0000, 8'h08, 3'b000, 3'b010};
    tbl[6] = '{3'b111, 6'b010101, 3'b000, 3'b100, 4'b0010, 4'b0000, 8'h08, 3'b000, 3'b100};
    tbl[7] = '{3'b111, 6'b010101, 3'b000, 3'b001, 4'b0010, 4'b0000, 8'h00, 3'b001, 3'b100};
    tbl[8] = '{3'b111, 6'b111000, 3'b010, 3'b111, 4'b1101, 4'b0100, 8'h90, 3'b010, 3'b001};
    tbl[9] = '{3'b000, 6'b000000, 3'b000, 3'b000, 4'b0000, 4'b0000, 8'h00, 3'b000, 3'b101};

    // reset held with requests present: outputs forced low
    reset_i = 1'b0;
    v_i     = 3'b111;
    bank_i  = 6'b010101;
    w_i     = 3'b000;
    #12;
    chk("rst_yumi", 32'(yumi3), 32'h0);
    chk("rst_bank_v", 32'(bv3), 32'h0);
    chk("rst_bank_port", 32'(bp3), 32'h0);
    chk("rst_rv", 32'(rv3), 32'h0);
    chk("rst_urgent", 32'(urg3), 32'h0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].bank, tbl[i].w);
      chk($sformatf("t%0d_yumi", i), 32'(yumi3), 32'(tbl[i].yumi));
      chk($sformatf("t%0d_bank_v", i), 32'(bv3), 32'(tbl[i].bv));
      chk($sformatf("t%0d_bank_w", i), 32'(bw3), 32'(tbl[i].bw));
      chk($sformatf("t%0d_bank_port", i), 32'(bp3), 32'(tbl[i].bp));
      chk($sformatf("t%0d_urgent", i), 32'(urg3), 32'(tbl[i].urg));
      chk($sformatf("t%0d_rv", i), 32'(rv3), 32'(tbl[i].rv));
    end

    // limit 7: p1 write vs p2 read on bank0
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(3'b110, 6'b000000, 3'b010);
      chk($sformatf("l7_c%0d_yumi", c), 32'(yumi7),
          (c == 7) ? 32'h2 : 32'h4);
      chk($sformatf("l7_c%0d_urgent", c), 32'(urg7),
          (c == 7) ? 32'h2 : 32'h0);
      chk($sformatf("l7_c%0d_bank_w", c), 32'(bw7),
          (c == 7) ? 32'h1 : 32'h0);
      chk($sformatf("l7_c%0d_bank_port", c), 32'(bp7),
          (c == 7) ? 32'h1 : 32'h2);
    end

    // limit 0: pure fixed priority
    do_reset();
    for (int c = 0; c < 50; c++) begin
      step(3'b111, 6'b010101, 3'b000);
      chk($sformatf("l0_c%0d_yumi", c), 32'(yumi0), 32'h4);
      chk($sformatf("l0_c%0d_urgent", c), 32'(urg0), 32'h0);
    end

    // asynchronous reset in the middle of a cycle
    do_reset();
    step(3'b111, 6'b010101, 3'b000);
    step(3'b111, 6'b010101, 3'b000);
    chk("ar_pre_yumi", 32'(yumi3), 32'h4);
    chk("ar_pre_rv", 32'(rv3), 32'h4);
    #1 reset_i = 1'b0;
    #1;
    chk("ar_yumi", 32'(yumi3), 32'h0);
    chk("ar_rv", 32'(rv3), 32'h0);
    chk("ar_bank_v", 32'(bv3), 32'h0);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("ar_rel_yumi", 32'(yumi3), 32'h4);
    chk("ar_rel_rv", 32'(rv3), 32'h0);
    chk("ar_rel_urgent", 32'(urg3), 32'h0);
    for (int c = 1; c < 4; c++) begin
      step(3'b111, 6'b010101, 3'b000);
      chk($sformatf("ar_c%0d_urgent", c), 32'(urg3),
          (c == 3) ? 32'h3 : 32'h0);
      chk($sformatf("ar_c%0d_yumi", c), 32'(yumi3),
          (c == 3) ? 32'h1 : 32'h4);
    end

    // port 0 stalls twice, drops, re-requests from zero
    do_reset();
    step(3'b101, 6'b010101, 3'b000);
    chk("sd_c0_yumi", 32'(yumi3), 32'h4);
    step(3'b101, 6'b010101, 3'b000);
    chk("sd_c1_yumi", 32'(yumi3), 32'h4);
    step(3'b100, 6'b010101, 3'b000);
    chk("sd_c2_urgent", 32'(urg3), 32'h0);
    for (int c = 3; c < 7; c++) begin
      step(3'b101, 6'b010101, 3'b000);
      chk($sformatf("sd_c%0d_urgent", c), 32'(urg3),
          (c == 6) ? 32'h1 : 32'h0);
      chk($sformatf("sd_c%0d_yumi", c), 32'(yumi3),
          (c == 6) ? 32'h1 : 32'h4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_bank_arb.md
Name:
bsg_manycore_bank_arb

Overview:
- Per-bank arbiter/scheduler for the tile's banked local memory.
- Shares the banks between three requesters: instruction fetch (port 0), remote-store network (port 1) and core data (port 2).
- Fixed priority (core data highest) plus per-port starvation aging, so a remote-store stream cannot be locked out indefinitely by local traffic.
- Issues yumi to requesters, a per-bank select to the bank muxes, and a registered read-valid return one cycle after each granted read.

Parameters:
- num_ports_p, 3: number of requesters; a higher index means higher base priority.
- num_banks_p, 4: number of memory banks.
- starve_limit_p, 7: consecutive stalled cycles before a port becomes urgent; 0 disables aging.
- bank_sel_width_lp, max(1,$clog2(num_banks_p)): width of a bank id (derived).
- port_id_width_lp, max(1,$clog2(num_ports_p)): width of a port id (derived).
- cnt_width_lp, max(1,$clog2(starve_limit_p+1)): width of a starvation counter (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. Asynchronous, active-low: asserted when 0.
- v_i  in  num_ports_p  request valid per port.
- bank_i  in  num_ports_p x bank_sel_width_lp  target bank per port (already swizzled).
- w_i  in  num_ports_p  1 = write, 0 = read.
- yumi_o  out  num_ports_p  request accepted this cycle.
- bank_v_o  out  num_banks_p  bank is accessed this cycle.
- bank_w_o  out  num_banks_p  write enable of the granted access.
- bank_port_o  out  num_banks_p x port_id_width_lp  port granted to each bank; 0 when idle.
- rv_o  out  num_ports_p  read data valid (one cycle after a granted read).
- urgent_o  out  num_ports_p  port is in the starved/urgent state (debug/perf).

Behaviour:
- Grant is combinational, per bank b, over candidates {p : v_i[p] & bank_i[p]==b}:
  - If any candidate is urgent, the lowest-index urgent candidate wins.
  - Otherwise the highest-index candidate wins.
  - A port targets exactly one bank, so it receives at most one grant.
- yumi_o[p] = granted[p]. Never asserted without v_i[p]. Same-cycle acceptance; the requester may change its request on the next cycle.
- bank_v_o[b] = any candidate for b. bank_w_o[b] = w_i of the winner; 0 when idle. bank_port_o[b] = winner index; 0 when idle.
- Read return: rv_o[p] registered, rv_o[p] <= yumi_o[p] & ~w_i[p]. Latency exactly 1 cycle. Writes produce no rv_o pulse.
- Starvation counter per port (cnt_width_lp bits):
  - v_i & ~yumi_o: cnt <= min(cnt+1, starve_limit_p).
  - yumi_o or ~v_i: cnt <= 0.
- urgent_o[p] = (starve_limit_p != 0) & (cnt[p] == starve_limit_p). The counter saturates and holds until the port is granted or drops v_i.
- starve_limit_p = 0: counters are held at 0, urgent_o stays 0, pure fixed priority.
- Simultaneous events:
  - Requests to distinct banks are all granted in the same cycle.
  - Several urgent ports on one bank: the lowest index is served first; the rest keep their saturated counters and win on later cycles.
- Reset (reset_i == 0, asynchronous):
  - rv_o = 0, all counters = 0, urgent_o = 0.
  - yumi_o, bank_v_o and bank_w_o are forced to 0 combinationally; bank_port_o = 0.
  - A read granted in the cycle before reset asserts produces no rv_o.
- Release: the first grants are evaluated in the first cycle with reset_i == 1, with all counters at 0.

Decomposition:
- Shared package bsg_manycore_bank_arb_pkg:
  - Port index constants: inst = 0, remote = 1, dmem = 2.
  - Width helper functions for bank and port ids.
- One natural sub-module, bsg_manycore_bank_arb_starve_ctr, instantiated per port:
  - Saturating counter; inputs v, yumi; output urgent.
- Per-bank select logic stays in a generate loop in the top module.

Test Plan:
1. starve_limit_p=3; ports 0,1,2 read bank 1 continuously → grant order p2,p2,p2,p0,p1,p2,…. urgent_o is 3'b011 at cycle 3 and 3'b010 at cycle 4.
2. Ports 0,1,2 target banks 0,2,3 with w_i=3'b010 → yumi_o=3'b111, bank_v_o=4'b1101, bank_port_o[2]=1, and rv_o=3'b101 on the next cycle.
3. Port 1 write to bank 0, port 2 read to bank 0, limit 7 → port 2 wins for 7 cycles; cycle 7 port 1 urgent and granted with bank_w_o[0]=1; its counter returns to 0.
4. starve_limit_p=0; same contention as test 1 → port 2 granted every cycle for 50 cycles; urgent_o is always 0.
5. During test 1 contention, drop reset_i to 0 mid-cycle → yumi_o and rv_o go to 0 immediately. After release, counters start at 0 and the first grant goes to p2.
6. Port 0 stalls 2 cycles, then deasserts v_i for 1 cycle → counter reads 0; re-request starts counting from 0.
